// File: rtl/ssd_pkg.sv
// Shared seven-segment definitions: segment patterns {a,b,c,d,e,f,g}, active-high,
// and the hex-to-segment lookup used by the scanner's decoder.
package ssd_pkg;

  localparam logic [6:0] SEG_0 = 7'b1111110;
  localparam logic [6:0] SEG_1 = 7'b0110000;
  localparam logic [6:0] SEG_2 = 7'b1101101;
  localparam logic [6:0] SEG_3 = 7'b1111001;
  localparam logic [6:0] SEG_4 = 7'b0110011;
  localparam logic [6:0] SEG_5 = 7'b1011011;
  localparam logic [6:0] SEG_6 = 7'b1011111;
  localparam logic [6:0] SEG_7 = 7'b1110000;
  localparam logic [6:0] SEG_8 = 7'b1111111;
  localparam logic [6:0] SEG_9 = 7'b1111011;
  localparam logic [6:0] SEG_A = 7'b1110111;
  localparam logic [6:0] SEG_B = 7'b0011111;
  localparam logic [6:0] SEG_C = 7'b1001110;
  localparam logic [6:0] SEG_D = 7'b0111101;
  localparam logic [6:0] SEG_E = 7'b1001111;
  localparam logic [6:0] SEG_F = 7'b1000111;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] hex);
    logic [6:0] seg;
    case (hex)
      4'h0:    seg = SEG_0;
      4'h1:    seg = SEG_1;
      4'h2:    seg = SEG_2;
      4'h3:    seg = SEG_3;
      4'h4:    seg = SEG_4;
      4'h5:    seg = SEG_5;
      4'h6:    seg = SEG_6;
      4'h7:    seg = SEG_7;
      4'h8:    seg = SEG_8;
      4'h9:    seg = SEG_9;
      4'hA:    seg = SEG_A;
      4'hB:    seg = SEG_B;
      4'hC:    seg = SEG_C;
      4'hD:    seg = SEG_D;
      4'hE:    seg = SEG_E;
      default: seg = SEG_F;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/ssd_hex_decoder.sv
// Hex nibble to active-high seven-segment pattern {a,b,c,d,e,f,g}.
module ssd_hex_decoder
  import ssd_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  // Pure lookup; output polarity is handled by the scanner.
  always_comb seg = hex_to_seg(hex);

endmodule

// File: rtl/ssd_scanner.sv
// Multiplexed seven-segment scanner with frame-synchronous double buffering,
// leading-zero suppression and per-slot PWM brightness.
module ssd_scanner
  import ssd_pkg::*;
#(
  parameter int NUM_DIGITS    = 8,
  parameter int SCAN_DIV_BITS = 17,
  parameter int ACTIVE_LOW    = 1
) (
  input  logic                    ClkPort,
  input  logic                    Reset,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] hex_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  input  logic                    lz_suppress,
  input  logic [3:0]              bright,
  output logic [NUM_DIGITS-1:0]   anode,
  output logic [6:0]              cathode,
  output logic                    dp,
  output logic                    frame_done
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
  localparam logic POL = (ACTIVE_LOW != 0);

  logic [SCAN_DIV_BITS-1:0] presc_r;
  logic [IDX_W-1:0]         idx_r;
  logic                     pending_r;
  logic [4*NUM_DIGITS-1:0]  sh_hex_r, act_hex_r;
  logic [NUM_DIGITS-1:0]    sh_dp_r, act_dp_r;
  logic [NUM_DIGITS-1:0]    sh_blank_r, act_blank_r;
  logic                     lz_r;
  logic [NUM_DIGITS-1:0]    anode_r;
  logic [6:0]               cathode_r;
  logic                     dp_r;
  logic                     frame_done_r;

  logic                     slot_term_s;
  logic                     commit_s;
  logic [NUM_DIGITS-1:0]    lz_mask_s;
  logic [NUM_DIGITS-1:0]    idx_oh_s;
  logic [3:0]               cur_nib_s;
  logic                     cur_dp_s;
  logic                     cur_blank_s;
  logic [6:0]               seg_s;
  logic [NUM_DIGITS-1:0]    anode_on_s;
  logic [6:0]               seg_on_s;
  logic                     dp_on_s;

  assign slot_term_s = (presc_r == {SCAN_DIV_BITS{1'b1}});
  assign commit_s    = slot_term_s && (idx_r == LAST_IDX);

  // Prescaler and digit index; the index wrap is the frame commit.
  always_ff @(posedge ClkPort or posedge Reset) begin
    if (Reset) begin
      presc_r <= {SCAN_DIV_BITS{1'b0}};
      idx_r   <= {IDX_W{1'b0}};
    end else begin
      presc_r <= presc_r + SCAN_DIV_BITS'(1);
      if (slot_term_s) begin
        idx_r <= (idx_r == LAST_IDX) ? {IDX_W{1'b0}} : idx_r + IDX_W'(1);
      end
    end
  end

  // Shadow capture and pending flag; a commit always consumes pending.
  always_ff @(posedge ClkPort or posedge Reset) begin
    if (Reset) begin
      sh_hex_r   <= {(4*NUM_DIGITS){1'b0}};
      sh_dp_r    <= {NUM_DIGITS{1'b0}};
      sh_blank_r <= {NUM_DIGITS{1'b0}};
      pending_r  <= 1'b0;
    end else begin
      if (load) begin
        sh_hex_r   <= hex_in;
        sh_dp_r    <= dp_in;
        sh_blank_r <= blank_in;
      end
      if (commit_s) begin
        pending_r <= 1'b0;
      end else if (load) begin
        pending_r <= 1'b1;
      end
    end
  end

  // Active display data; a load on the commit cycle bypasses the shadow.
  always_ff @(posedge ClkPort or posedge Reset) begin
    if (Reset) begin
      act_hex_r   <= {(4*NUM_DIGITS){1'b0}};
      act_dp_r    <= {NUM_DIGITS{1'b0}};
      act_blank_r <= {NUM_DIGITS{1'b0}};
      lz_r        <= 1'b0;
    end else if (commit_s && (load || pending_r)) begin
      act_hex_r   <= load ? hex_in   : sh_hex_r;
      act_dp_r    <= load ? dp_in    : sh_dp_r;
      act_blank_r <= load ? blank_in : sh_blank_r;
      lz_r        <= lz_suppress;
    end
  end

  // Leading-zero mask: walk down from the top digit until a nonzero nibble.
  always_comb begin : lz_scan
    logic lead_s;
    lz_mask_s = {NUM_DIGITS{1'b0}};
    lead_s    = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      if (lead_s && (act_hex_r[4*k +: 4] == 4'h0)) begin
        lz_mask_s[k] = 1'b1;
      end else begin
        lead_s = 1'b0;
      end
    end
  end

  // Select the data of the digit currently being scanned.
  always_comb begin
    cur_nib_s   = 4'h0;
    cur_dp_s    = 1'b0;
    cur_blank_s = 1'b0;
    idx_oh_s    = {NUM_DIGITS{1'b0}};
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx_r == IDX_W'(k)) begin
        cur_nib_s   = act_hex_r[4*k +: 4];
        cur_dp_s    = act_dp_r[k];
        cur_blank_s = act_blank_r[k] | (lz_r & lz_mask_s[k]);
        idx_oh_s[k] = 1'b1;
      end else begin
        idx_oh_s[k] = 1'b0;
      end
    end
  end

  ssd_hex_decoder u_dec (
    .hex (cur_nib_s),
    .seg (seg_s)
  );

  // Active-high drive values before the output register.
  always_comb begin
    if (presc_r[SCAN_DIV_BITS-1 -: 4] < bright) begin
      anode_on_s = idx_oh_s;
    end else begin
      anode_on_s = {NUM_DIGITS{1'b0}};
    end
    if (cur_blank_s) begin
      seg_on_s = 7'b0000000;
      dp_on_s  = 1'b0;
    end else begin
      seg_on_s = seg_s;
      dp_on_s  = cur_dp_s;
    end
  end

  // Registered pin drive with polarity applied; reset leaves everything dark.
  always_ff @(posedge ClkPort or posedge Reset) begin
    if (Reset) begin
      anode_r      <= {NUM_DIGITS{POL}};
      cathode_r    <= {7{POL}};
      dp_r         <= POL;
      frame_done_r <= 1'b0;
    end else begin
      anode_r      <= anode_on_s ^ {NUM_DIGITS{POL}};
      cathode_r    <= seg_on_s ^ {7{POL}};
      dp_r         <= dp_on_s ^ POL;
      frame_done_r <= commit_s;
    end
  end

  assign anode      = anode_r;
  assign cathode    = cathode_r;
  assign dp         = dp_r;
  assign frame_done = frame_done_r;

endmodule

// File: tb/tb_ssd_scanner.sv
// Self-checking bench for ssd_scanner (4 digits, 32-cycle slots, active-low pins).
module tb_ssd_scanner;

  localparam int ND    = 4;
  localparam int SDB   = 5;
  localparam int SLOT  = 1 << SDB;
  localparam int FRAME = ND * SLOT;

  logic        ClkPort = 1'b0;
  logic        Reset;
  logic        load;
  logic [15:0] hex_in;
  logic [3:0]  dp_in;
  logic [3:0]  blank_in;
  logic        lz_suppress;
  logic [3:0]  bright;
  logic [3:0]  anode;
  logic [6:0]  cathode;
  logic        dp;
  logic        frame_done;

  int n_checks = 0;
  int n_fail   = 0;
  int n        = 0;
  int on_cnt[ND];

  // Reference state: what the display shows this frame, and what waits for the next.
  logic [15:0] m_hex, s_hex;
  logic [3:0]  m_dp, m_blank, s_dp, s_blank;
  logic        m_lz, m_pend;

  string glyph[16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
                       "abcdefg", "abcdfg", "abcefg", "cdefg", "adef", "bcdeg", "adefg", "aefg"};

  always #5 ClkPort = ~ClkPort;

  ssd_scanner #(.NUM_DIGITS(ND), .SCAN_DIV_BITS(SDB), .ACTIVE_LOW(1)) dut (
    .ClkPort     (ClkPort),
    .Reset       (Reset),
    .load        (load),
    .hex_in      (hex_in),
    .dp_in       (dp_in),
    .blank_in    (blank_in),
    .lz_suppress (lz_suppress),
    .bright      (bright),
    .anode       (anode),
    .cathode     (cathode),
    .dp          (dp),
    .frame_done  (frame_done)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, n);
    end
  endtask

  function automatic logic [6:0] segs(input string s);
    logic [6:0] v;
    v = 7'b0000000;
    for (int i = 0; i < s.len(); i++) v[6 - (int'(s[i]) - 97)] = 1'b1;
    return v;
  endfunction

  task automatic model_reset();
    m_hex = 16'h0000; s_hex = 16'h0000;
    m_dp = 4'h0; m_blank = 4'h0; s_dp = 4'h0; s_blank = 4'h0;
    m_lz = 1'b0; m_pend = 1'b0;
    n = 0;
  endtask

  // One clock: check the outputs against the reference, then advance the reference.
  task automatic step();
    int pre, slot, dig, top;
    logic blank;
    logic [3:0] exp_an;
    logic [6:0] exp_cat;
    logic exp_dp;
    @(posedge ClkPort);
    #1;
    n++;
    pre  = n - 1;
    slot = pre % SLOT;
    dig  = (pre / SLOT) % ND;
    top  = 0;
    for (int k = 0; k < ND; k++) if (m_hex[4*k +: 4] != 4'h0) top = k;
    blank   = m_blank[dig] || (m_lz && dig > top);
    exp_an  = ((slot * 16) / SLOT < int'(bright)) ? ~(4'b0001 << dig) : 4'b1111;
    exp_cat = blank ? 7'h7f : ~segs(glyph[m_hex[4*dig +: 4]]);
    exp_dp  = ~(m_dp[dig] & ~blank);
    check_eq("anode", anode, exp_an);
    check_eq("cathode", cathode, exp_cat);
    check_eq("dp", dp, exp_dp);
    check_eq("frame_done", frame_done, (n % FRAME == 0) ? 1 : 0);
    if (anode === ~(4'b0001 << dig)) on_cnt[dig]++;
    if (n % FRAME == 0) begin
      if (load) begin
        m_hex = hex_in; m_dp = dp_in; m_blank = blank_in; m_lz = lz_suppress;
      end else if (m_pend) begin
        m_hex = s_hex; m_dp = s_dp; m_blank = s_blank; m_lz = lz_suppress;
      end
      m_pend = 1'b0;
    end else if (load) begin
      s_hex = hex_in; s_dp = dp_in; s_blank = blank_in; m_pend = 1'b1;
    end
  endtask

  task automatic run(input int cycles);
    for (int i = 0; i < cycles; i++) step();
  endtask

  task automatic run_until(input int phase);
    while (n % FRAME != phase) step();
  endtask

  task automatic pulse_load(input logic [15:0] h, input logic [3:0] d, input logic [3:0] b);
    hex_in = h; dp_in = d; blank_in = b; load = 1'b1;
    step();
    load = 1'b0;
  endtask

  task automatic check_off(input string tag);
    check_eq({tag, "_anode"}, anode, 4'b1111);
    check_eq({tag, "_cathode"}, cathode, 7'h7f);
    check_eq({tag, "_dp"}, dp, 1'b1);
    check_eq({tag, "_frame_done"}, frame_done, 1'b0);
  endtask

  initial begin
    Reset = 1'b1; load = 1'b0; hex_in = 16'h0000; dp_in = 4'h0; blank_in = 4'h0;
    lz_suppress = 1'b0; bright = 4'd15;
    model_reset();
    repeat (3) @(posedge ClkPort);
    #1;
    check_off("reset");
    Reset = 1'b0;

    // Reset release: full-brightness scan, first frame_done at 128.
    run(2 * FRAME);

    // Mid-frame load stays invisible until commit.
    run_until(40);
    pulse_load(16'h1234, 4'b0101, 4'b0000);
    run_until(0);
    run(FRAME);

    // Leading-zero suppression, including dp drop on suppressed digits.
    lz_suppress = 1'b1;
    run_until(10);
    pulse_load(16'h0050, 4'b1111, 4'b0000);
    run_until(0);
    run(FRAME);
    pulse_load(16'h0000, 4'b0000, 4'b0000);
    run_until(0);
    run(FRAME);

    // Brightness duty.
    lz_suppress = 1'b0;
    pulse_load(16'h8888, 4'b0000, 4'b0010);
    bright = 4'd4;
    run_until(0);
    for (int d = 0; d < ND; d++) on_cnt[d] = 0;
    run(FRAME);
    for (int d = 0; d < ND; d++) check_eq($sformatf("duty4_d%0d", d), on_cnt[d], 8);
    bright = 4'd0;
    run_until(0);
    run(1);
    for (int d = 0; d < ND; d++) on_cnt[d] = 0;
    run(FRAME);
    check_eq("duty0_total", on_cnt[0] + on_cnt[1] + on_cnt[2] + on_cnt[3], 0);

    // Load coincident with commit overrides a pending mid-frame load.
    bright = 4'd15;
    run_until(20);
    pulse_load(16'h1111, 4'b0000, 4'b0000);
    run_until(FRAME - 1);
    pulse_load(16'hABCD, 4'b0000, 4'b0000);
    run(2 * FRAME);

    // Randomized traffic.
    for (int i = 0; i < 20 * FRAME; i++) begin
      if ($urandom_range(0, 15) == 0) bright = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 59) == 0) begin
        lz_suppress = 1'($urandom_range(0, 1));
        pulse_load(16'($urandom) >> (4 * $urandom_range(0, 4)),
                   4'($urandom), 4'($urandom_range(0, 3) == 0 ? $urandom : 0));
      end else begin
        step();
      end
    end

    // Reset mid-frame with a load pending: dark at once, no stale commit afterwards.
    bright = 4'd15;
    lz_suppress = 1'b0;
    run_until(50);
    pulse_load(16'h9999, 4'b1111, 4'b0000);
    run(5);
    Reset = 1'b1;
    #1;
    check_off("midreset");
    repeat (2) @(posedge ClkPort);
    #1;
    Reset = 1'b0;
    model_reset();
    run(2 * FRAME);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ssd_scanner.md
SSD_SCANNER -- requirements
Module: ssd_scanner

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 8, number of multiplexed digits (legal 1..8).
REQ-002 SHALL have parameter SCAN_DIV_BITS, default 17, log2 of clock cycles per digit slot (legal 5..24).
REQ-003 SHALL have parameter ACTIVE_LOW, default 1; when 1, anode, cathode and dp outputs drive 0 for on.
REQ-004 SHALL have port ClkPort  in  1  system clock, 100 MHz.
REQ-005 SHALL have port Reset  in  1  asynchronous, active-high reset.
REQ-006 SHALL have port load  in  1  single-cycle strobe capturing hex_in, dp_in and blank_in into shadow registers.
REQ-007 SHALL have port hex_in  in  4*NUM_DIGITS  nibble k is the value for digit k; digit 0 is rightmost.
REQ-008 SHALL have port dp_in  in  NUM_DIGITS  per-digit decimal point request.
REQ-009 SHALL have port blank_in  in  NUM_DIGITS  per-digit forced blank.
REQ-010 SHALL have port lz_suppress  in  1  leading-zero suppression enable, sampled at frame commit.
REQ-011 SHALL have port bright  in  4  brightness duty in sixteenths, sampled every cycle.
REQ-012 SHALL have port anode  out  NUM_DIGITS  one-hot digit enable.
REQ-013 SHALL have port cathode  out  7  segments {a,b,c,d,e,f,g}.
REQ-014 SHALL have port dp  out  1  decimal point segment.
REQ-015 SHALL have port frame_done  out  1  one-cycle pulse at each frame commit.

Function
REQ-016 SHALL count a prescaler from 0 to 2^SCAN_DIV_BITS-1 and wrap; the wrap cycle is the slot terminal.
REQ-017 SHALL advance the digit index by 1 on each slot terminal, wrapping NUM_DIGITS-1 -> 0; the wrap to 0 is the frame commit.
REQ-018 SHALL, on load, overwrite the shadow registers and set a pending flag; when several loads occur within one frame, the last one wins.
REQ-019 SHALL, at frame commit with pending set, copy shadow to active registers, latch lz_suppress, and clear pending; active data never changes mid-frame.
REQ-020 SHALL, when load coincides with frame commit, commit the new hex_in, dp_in and blank_in directly and leave pending clear.
REQ-021 SHALL pulse frame_done for exactly the commit cycle, whether or not new data was committed.
REQ-022 SHALL, with lz_suppress latched at 1, blank each digit from NUM_DIGITS-1 downward whose nibble is 0 until the first nonzero nibble; digit 0 is never suppressed; suppressed digits also drop dp.
REQ-023 SHALL show a blanked digit (blank_in bit or suppression) with all segments and dp off; its anode still follows REQ-024.
REQ-024 SHALL enable the current anode only while prescaler[SCAN_DIV_BITS-1:SCAN_DIV_BITS-4] < bright; bright=0 gives all anodes off; bright=15 gives 15/16 duty.
REQ-025 SHALL decode hex to segments as 0..F standard (0:abcdef, 1:bc, 7:abc, 8:all, A:abcefg, b:cdefg, C:adef, d:bcdeg, E:adefg, F:aefg).
REQ-026 SHALL register anode, cathode and dp; they reflect a new index or prescaler value one cycle later.
REQ-027 SHALL never assert more than one anode at a time.

Reset
REQ-028 SHALL, while Reset is high, force prescaler 0, index 0, pending 0, shadow and active registers 0, lz latch 0, frame_done 0, all anodes off, all cathodes off, dp off.
REQ-029 SHALL, after Reset falls, begin slot 0 of digit 0, with first frame_done after NUM_DIGITS*2^SCAN_DIV_BITS cycles.
REQ-030 SHALL discard any pending load when Reset asserts mid-frame.

Structure
REQ-031 SHALL place the segment pattern constants and the hex-to-segment function in shared package ssd_pkg.
REQ-032 SHALL implement decoding in one sub-module ssd_hex_decoder (4-bit in, 7-bit active-high out); polarity inversion occurs in ssd_scanner.
REQ-033 SHALL be instantiable in the top level as a drop-in replacement for inline 8-digit scan logic with default parameters.

Verification (SCAN_DIV_BITS=5, NUM_DIGITS=4 unless noted)
REQ-034 SHALL check reset release with bright=15: anode cycles 1110,1101,1011,0111 (ACTIVE_LOW) every 32 cycles, and frame_done first pulses at cycle 128.
REQ-035 SHALL check load hex_in=16'h1234 mid-frame: cathode values stay at the old data until the commit; the next frame shows 4,3,2,1 on digits 0..3.
REQ-036 SHALL check lz_suppress=1 with hex_in=16'h0050: digits 3 and 2 are blank, digit 1 shows 5, digit 0 shows 0; with hex_in=16'h0000, only digit 0 shows 0.
REQ-037 SHALL check bright=4: each anode is on for exactly 8 of 32 slot cycles; bright=0: anode stays all ones for a full frame.
REQ-038 SHALL check load asserted on the commit cycle with hex_in=16'hABCD: the following frame shows D,C,B,A, and pending stays 0.
REQ-039 SHALL check Reset pulsed mid-frame after a pending load: all outputs go off immediately, and the data after release is 0000 with no stale commit.
